ifu: RTL and testbench
======================

IFU -- requirements
Module: ifu

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Ports SHALL be:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- ifu_valid  in  1  one-cycle start-fetch pulse from the control FSM.
- ifu_finish  out  1  one-cycle pulse; instr and pc are valid.
- flush_i  in  1  redirect request from the trap controller.
- new_pc_i  in  64  redirect target; sampled when flush_i=1.
- pc_update_i  in  1  one-cycle pulse at writeback; commits next_pc_i.
- next_pc_i  in  64  sequential or branch target from the execute stage.
- ireq_valid  out  1  instruction bus request.
- ireq_addr  out  64  fetch address; equals the current PC.
- iresp_data_ok  in  1  bus data-return strobe.
- iresp_data  in  32  returned instruction word.
- instr  out  32  latched instruction.
- pc  out  64  PC of the latched instruction.
- misaligned_inst  out  1  fetch-address-misaligned exception flag.

Function
REQ-003 The PC register SHALL hold the address of the next fetch.
REQ-004 PC update priority, highest first: flush_i loads new_pc_i; then pc_update_i loads next_pc_i; otherwise the PC holds.
REQ-005 The FSM SHALL have four states: IDLE, REQ, DONE and DISCARD.
REQ-006 IDLE to REQ SHALL occur when ifu_valid=1 and flush_i=0. ireq_valid SHALL rise the cycle after ifu_valid.
REQ-007 In REQ, ireq_valid=1 and ireq_addr=PC SHALL be held stable until iresp_data_ok.
REQ-008 REQ to DONE SHALL occur on iresp_data_ok=1. In the same edge, instr captures iresp_data and pc captures the PC.
REQ-009 In DONE, ifu_finish=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-010 Minimum latency from ifu_valid to ifu_finish SHALL be 3 cycles, reached when data_ok arrives in the first REQ cycle.
REQ-011 flush_i in REQ without data_ok SHALL move to DISCARD. ireq_valid stays high until data_ok; that data is dropped and the FSM returns to IDLE with no ifu_finish.
REQ-012 flush_i and data_ok in the same REQ cycle SHALL drop the data and move to IDLE.
REQ-013 flush_i in DONE SHALL still emit ifu_finish, and the PC takes new_pc_i.
REQ-014 ifu_valid outside IDLE SHALL be ignored.
REQ-015 instr and pc SHALL hold their value until the next successful capture.

Reset
REQ-016 Reset SHALL set: state=IDLE, PC=64'h8000_0000, pc=64'h8000_0000, instr=0, ireq_valid=0, ifu_finish=0, misaligned_inst=0.
REQ-017 Reset asserted mid-request SHALL abandon the request immediately. A later data_ok SHALL be ignored while in IDLE.

Configuration
REQ-018 Macro IFU_MISALIGN_CHECK_EN SHALL control the misalignment check.
- Defined: if ifu_valid arrives with PC[1:0]!=0, no bus request is issued. The FSM goes directly to DONE, misaligned_inst=1 with ifu_finish, instr=0, pc=PC. misaligned_inst clears on the next ifu_valid.
- Undefined: misaligned_inst is tied to 0, and fetch uses the PC unmodified.

Structure
REQ-019 The state enum ifu_state_t and constant RESET_PC=64'h8000_0000 SHALL live in the shared param package.
REQ-020 The PC register with flush/update priority SHALL be a sub-module named ifu_pc. The FSM and bus handshake stay in ifu.

Verification
REQ-021 Reset, then ifu_valid, with data_ok in the first REQ cycle and data 32'h00000013 -> ireq_addr=0x80000000; ifu_finish 3 cycles after ifu_valid; instr=0x00000013; pc=0x80000000.
REQ-022 Bus stalls 5 cycles -> ireq_valid and ireq_addr remain stable all 5 cycles; exactly one ifu_finish pulse.
REQ-023 flush_i with new_pc_i=0x80001000 in the second REQ cycle, data_ok 2 cycles later -> no ifu_finish. The next fetch uses ireq_addr=0x80001000.
REQ-024 pc_update_i with next_pc_i=0x80000004 together with flush_i and new_pc_i=0x80000100 -> PC=0x80000100.
REQ-025 With IFU_MISALIGN_CHECK_EN, PC=0x80000002, then ifu_valid -> ireq_valid never rises; ifu_finish=1 and misaligned_inst=1 in the same cycle.
REQ-026 Reset asserted in REQ, then data_ok the following cycle -> state IDLE, no ifu_finish, instr=0.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg -- shared definitions for the instruction fetch unit.
//   ifu_state_t     : fetch FSM state encoding (IDLE, REQ, DONE, DISCARD)
//   RESET_PC        : address of the first fetch after reset
//   is_misaligned() : true when a fetch address is not 4-byte aligned
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DONE    = 2'd2,
        DISCARD = 2'd3
    } ifu_state_t;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    function automatic logic is_misaligned(input logic [63:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_pc.sv
// ifu_pc -- program counter register for the fetch unit.
// Holds the address of the next fetch.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (PC <= RESET_PC)
//   flush_i    : redirect; loads new_pc_i (highest priority)
//   new_pc_i   : redirect target
//   update_i   : writeback commit; loads next_pc_i
//   next_pc_i  : sequential / branch target
//   pc_q       : current PC
module ifu_pc
    import ifu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [63:0] new_pc_i,
    input  logic        update_i,
    input  logic [63:0] next_pc_i,
    output logic [63:0] pc_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (flush_i) begin
            pc_q <= new_pc_i;
        end else if (update_i) begin
            pc_q <= next_pc_i;
        end
    end

endmodule

// File: rtl/ifu.sv
// ifu -- instruction fetch unit: FSM plus instruction-bus handshake.
// Optional feature: define IFU_MISALIGN_CHECK_EN to enable the fetch-address
// misalignment check; otherwise misaligned_inst is tied low.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   ifu_valid         : one-cycle start-fetch pulse (honoured only in IDLE)
//   ifu_finish        : one-cycle pulse; instr/pc hold the fetched result
//   flush_i, new_pc_i : redirect request and target
//   pc_update_i       : writeback commit pulse, next_pc_i is the new PC
//   ireq_valid        : bus request, ireq_addr is the fetch address
//   iresp_data_ok     : bus data strobe, iresp_data is the instruction
//   instr, pc         : latched instruction and its address
//   misaligned_inst   : fetch-address-misaligned exception flag
// Bus handshake: ireq_valid is raised with ireq_addr and both stay stable
// until the cycle iresp_data_ok is seen high; that cycle completes the
// transfer. A redirect while the request is outstanding cannot withdraw it,
// so the FSM waits in DISCARD for the data and drops it.
// Latency: ifu_valid cycle, one REQ cycle, then ifu_finish in the DONE cycle,
// i.e. ifu_finish in the third cycle when data returns in the first REQ cycle.
module ifu
    import ifu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_valid,
    output logic        ifu_finish,
    input  logic        flush_i,
    input  logic [63:0] new_pc_i,
    input  logic        pc_update_i,
    input  logic [63:0] next_pc_i,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic [31:0] instr,
    output logic [63:0] pc,
    output logic        misaligned_inst
);

    ifu_state_t  state;
    ifu_state_t  state_next;
    logic [63:0] pc_cur;
    logic [63:0] fetch_addr;
    logic        capture;
`ifdef IFU_MISALIGN_CHECK_EN
    logic        mis_start;
`endif

    ifu_pc u_pc (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush_i),
        .new_pc_i  (new_pc_i),
        .update_i  (pc_update_i),
        .next_pc_i (next_pc_i),
        .pc_q      (pc_cur)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ifu_finish = 1'b0;
        ireq_valid = 1'b0;
        ireq_addr  = pc_cur;
        capture    = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
        mis_start  = 1'b0;
`endif
        case (state)
            IDLE: begin
                // A redirect in the same cycle wins over the start pulse.
                if (ifu_valid && !flush_i) begin
`ifdef IFU_MISALIGN_CHECK_EN
                    if (is_misaligned(pc_cur)) begin
                        state_next = DONE;
                        mis_start  = 1'b1;
                    end else begin
                        state_next = REQ;
                    end
`else
                    state_next = REQ;
`endif
                end
            end
            REQ: begin
                ireq_valid = 1'b1;
                ireq_addr  = fetch_addr;
                if (iresp_data_ok) begin
                    state_next = flush_i ? IDLE : DONE;
                    capture    = !flush_i;
                end else if (flush_i) begin
                    state_next = DISCARD;
                end
            end
            DONE: begin
                ifu_finish = 1'b1;
                state_next = IDLE;
            end
            DISCARD: begin
                ireq_valid = 1'b1;
                ireq_addr  = fetch_addr;
                if (iresp_data_ok) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Tracks the PC while idle so the address is frozen on leaving IDLE and
    // stays stable on the bus even if a redirect changes the PC mid-request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_addr <= RESET_PC;
        end else if (state == IDLE) begin
            fetch_addr <= pc_cur;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr <= 32'd0;
            pc    <= RESET_PC;
        end else if (capture) begin
            instr <= iresp_data;
            pc    <= fetch_addr;
`ifdef IFU_MISALIGN_CHECK_EN
        end else if (mis_start) begin
            instr <= 32'd0;
            pc    <= pc_cur;
`endif
        end
    end

`ifdef IFU_MISALIGN_CHECK_EN
    // Flag stays up after the exception until the next accepted start pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misaligned_inst <= 1'b0;
        end else if (state == IDLE && ifu_valid && !flush_i) begin
            misaligned_inst <= mis_start;
        end
    end
`else
    assign misaligned_inst = 1'b0;
`endif

endmodule

// File: tb/tb_ifu.sv
module tb_ifu;

    logic        clk;
    logic        rst;
    logic        ifu_valid;
    logic        ifu_finish;
    logic        flush_i;
    logic [63:0] new_pc_i;
    logic        pc_update_i;
    logic [63:0] next_pc_i;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        misaligned_inst;

    ifu dut (
        .clk             (clk),
        .rst             (rst),
        .ifu_valid       (ifu_valid),
        .ifu_finish      (ifu_finish),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .pc_update_i     (pc_update_i),
        .next_pc_i       (next_pc_i),
        .ireq_valid      (ireq_valid),
        .ireq_addr       (ireq_addr),
        .iresp_data_ok   (iresp_data_ok),
        .iresp_data      (iresp_data),
        .instr           (instr),
        .pc              (pc),
        .misaligned_inst (misaligned_inst)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    int finish_cnt;
    int f0;

    always @(negedge clk) begin
        if (ifu_finish) finish_cnt++;
    end

    // ---------------- check helpers ----------------
    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %016h expected %016h", name, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic pc_pulse(input logic upd, input logic [63:0] nxt,
                            input logic fl, input logic [63:0] npc);
        step();
        pc_update_i = upd;
        next_pc_i   = nxt;
        flush_i     = fl;
        new_pc_i    = npc;
        step();
        pc_update_i = 1'b0;
        flush_i     = 1'b0;
    endtask

    // Full fetch: ifu_valid, 'stall' REQ cycles without data, then data_ok.
    task automatic fetch(input int stall, input logic [31:0] data,
                         input logic [63:0] addr, input string tag);
        int base;
        step();
        ifu_valid = 1'b1;
        base = finish_cnt;
        sample();
        chk1({tag, " no_req_in_valid_cycle"}, ireq_valid, 1'b0);
        step();
        ifu_valid = 1'b0;
        for (int k = 0; k < stall; k++) begin
            sample();
            chk1({tag, " stall_valid"}, ireq_valid, 1'b1);
            chk64({tag, " stall_addr"}, ireq_addr, addr);
            chk1({tag, " stall_no_finish"}, ifu_finish, 1'b0);
            step();
        end
        iresp_data_ok = 1'b1;
        iresp_data    = data;
        sample();
        chk1({tag, " req_valid"}, ireq_valid, 1'b1);
        chk64({tag, " req_addr"}, ireq_addr, addr);
        chk1({tag, " req_no_finish"}, ifu_finish, 1'b0);
        step();
        iresp_data_ok = 1'b0;
        iresp_data    = 32'd0;
        sample();
        chk1({tag, " finish"}, ifu_finish, 1'b1);
        chk32({tag, " instr"}, instr, data);
        chk64({tag, " pc"}, pc, addr);
        chk1({tag, " done_no_req"}, ireq_valid, 1'b0);
        step();
        sample();
        chk1({tag, " finish_drop"}, ifu_finish, 1'b0);
        step();
        chk_int({tag, " finish_count"}, finish_cnt, base + 1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        upd;
        logic [63:0] next_pc;
        logic        fl;
        logic [63:0] new_pc;
        int          stall;
        logic [31:0] data;
        logic [63:0] exp_addr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        checks        = 0;
        errors        = 0;
        finish_cnt    = 0;
        rst           = 1'b1;
        ifu_valid     = 1'b0;
        flush_i       = 1'b0;
        new_pc_i      = 64'd0;
        pc_update_i   = 1'b0;
        next_pc_i     = 64'd0;
        iresp_data_ok = 1'b0;
        iresp_data    = 32'd0;

        vecs[0] = '{1'b0, 64'h0,           1'b0, 64'h0,           0, 32'h0000_0013, 64'h8000_0000};
        vecs[1] = '{1'b1, 64'h8000_0004,   1'b0, 64'h0,           5, 32'h0010_0093, 64'h8000_0004};
        vecs[2] = '{1'b1, 64'h8000_0004,   1'b1, 64'h8000_0100,   1, 32'hdead_beef, 64'h8000_0100};
        vecs[3] = '{1'b0, 64'h0,           1'b1, 64'h8000_2000,   2, 32'h1234_5678, 64'h8000_2000};
        vecs[4] = '{1'b1, 64'h8000_2008,   1'b0, 64'h0,           0, 32'hcafe_f00d, 64'h8000_2008};

        // reset state
        sample();
        chk1("rst finish", ifu_finish, 1'b0);
        chk1("rst ireq_valid", ireq_valid, 1'b0);
        chk32("rst instr", instr, 32'd0);
        chk64("rst pc", pc, 64'h8000_0000);
        chk64("rst ireq_addr", ireq_addr, 64'h8000_0000);
        chk1("rst misaligned", misaligned_inst, 1'b0);
        step();
        rst = 1'b0;

        // table-driven fetches
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].upd || vecs[i].fl)
                pc_pulse(vecs[i].upd, vecs[i].next_pc, vecs[i].fl, vecs[i].new_pc);
            sample();
            chk64($sformatf("vec%0d idle_addr", i), ireq_addr, vecs[i].exp_addr);
            fetch(vecs[i].stall, vecs[i].data, vecs[i].exp_addr, $sformatf("vec%0d", i));
        end

        // flush in the second REQ cycle, data two cycles later: dropped
        f0 = finish_cnt;
        step();
        ifu_valid = 1'b1;
        step();
        ifu_valid = 1'b0;
        step();
        flush_i  = 1'b1;
        new_pc_i = 64'h8000_1000;
        step();
        flush_i = 1'b0;
        sample();
        chk1("discard valid_held", ireq_valid, 1'b1);
        chk64("discard addr_held", ireq_addr, 64'h8000_2008);
        step();
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hffff_ffff;
        sample();
        chk1("discard valid_at_data", ireq_valid, 1'b1);
        step();
        iresp_data_ok = 1'b0;
        sample();
        chk1("discard back_idle", ireq_valid, 1'b0);
        chk1("discard no_finish", ifu_finish, 1'b0);
        step();
        chk_int("discard finish_count", finish_cnt, f0);
        chk32("discard instr_kept", instr, 32'hcafe_f00d);
        fetch(0, 32'h0000_0297, 64'h8000_1000, "after_discard");

        // flush together with data_ok: data dropped, straight to IDLE
        f0 = finish_cnt;
        step();
        ifu_valid = 1'b1;
        step();
        ifu_valid     = 1'b0;
        flush_i       = 1'b1;
        new_pc_i      = 64'h8000_4000;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hffff_0000;
        sample();
        chk1("flush_data req", ireq_valid, 1'b1);
        step();
        flush_i       = 1'b0;
        iresp_data_ok = 1'b0;
        sample();
        chk1("flush_data idle", ireq_valid, 1'b0);
        chk1("flush_data no_finish", ifu_finish, 1'b0);
        chk64("flush_data new_pc", ireq_addr, 64'h8000_4000);
        step();
        chk_int("flush_data finish_count", finish_cnt, f0);
        chk32("flush_data instr_kept", instr, 32'h0000_0297);

        // flush in DONE: finish still emitted, PC redirected
        step();
        ifu_valid = 1'b1;
        step();
        ifu_valid     = 1'b0;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h00a0_0513;
        step();
        iresp_data_ok = 1'b0;
        flush_i       = 1'b1;
        new_pc_i      = 64'h8000_3000;
        sample();
        chk1("flush_done finish", ifu_finish, 1'b1);
        chk32("flush_done instr", instr, 32'h00a0_0513);
        chk64("flush_done pc", pc, 64'h8000_4000);
        step();
        flush_i = 1'b0;
        sample();
        chk1("flush_done finish_drop", ifu_finish, 1'b0);
        chk64("flush_done redirect", ireq_addr, 64'h8000_3000);
        fetch(1, 32'h00b0_0593, 64'h8000_3000, "after_flush_done");

        // ifu_valid in REQ and DONE is ignored
        f0 = finish_cnt;
        step();
        ifu_valid = 1'b1;
        step();
        sample();
        chk1("ignore req", ireq_valid, 1'b1);
        step();
        ifu_valid     = 1'b0;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h00c0_0613;
        step();
        iresp_data_ok = 1'b0;
        ifu_valid     = 1'b1;
        sample();
        chk1("ignore finish", ifu_finish, 1'b1);
        step();
        ifu_valid = 1'b0;
        sample();
        chk1("ignore no_new_req", ireq_valid, 1'b0);
        chk1("ignore finish_drop", ifu_finish, 1'b0);
        step();
        chk_int("ignore finish_count", finish_cnt, f0 + 1);
        chk32("ignore instr", instr, 32'h00c0_0613);
        chk64("ignore pc", pc, 64'h8000_3000);

        // misaligned PC
        pc_pulse(1'b1, 64'h8000_0002, 1'b0, 64'h0);
`ifdef IFU_MISALIGN_CHECK_EN
        f0 = finish_cnt;
        step();
        ifu_valid = 1'b1;
        sample();
        chk1("mis no_req0", ireq_valid, 1'b0);
        step();
        ifu_valid = 1'b0;
        sample();
        chk1("mis finish", ifu_finish, 1'b1);
        chk1("mis flag", misaligned_inst, 1'b1);
        chk1("mis no_req1", ireq_valid, 1'b0);
        chk32("mis instr", instr, 32'd0);
        chk64("mis pc", pc, 64'h8000_0002);
        step();
        sample();
        chk1("mis finish_drop", ifu_finish, 1'b0);
        chk1("mis no_req2", ireq_valid, 1'b0);
        chk1("mis flag_held", misaligned_inst, 1'b1);
        step();
        chk_int("mis finish_count", finish_cnt, f0 + 1);
        pc_pulse(1'b1, 64'h8000_0010, 1'b0, 64'h0);
        fetch(0, 32'h00d0_0693, 64'h8000_0010, "after_mis");
        chk1("mis flag_cleared", misaligned_inst, 1'b0);
`else
        fetch(0, 32'h00d0_0693, 64'h8000_0002, "unaligned_plain");
        chk1("plain misaligned_low", misaligned_inst, 1'b0);
`endif

        // reset in REQ, data_ok afterwards is ignored
        f0 = finish_cnt;
        step();
        ifu_valid = 1'b1;
        step();
        ifu_valid = 1'b0;
        sample();
        chk1("rst_req req", ireq_valid, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk1("rst_req abandon", ireq_valid, 1'b0);
        chk32("rst_req instr", instr, 32'd0);
        chk64("rst_req pc", pc, 64'h8000_0000);
        step();
        rst           = 1'b0;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hdead_beef;
        sample();
        chk1("rst_req idle", ireq_valid, 1'b0);
        chk1("rst_req no_finish0", ifu_finish, 1'b0);
        step();
        iresp_data_ok = 1'b0;
        sample();
        chk1("rst_req no_finish1", ifu_finish, 1'b0);
        chk32("rst_req instr_zero", instr, 32'd0);
        chk64("rst_req addr", ireq_addr, 64'h8000_0000);
        step();
        chk_int("rst_req finish_count", finish_cnt, f0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
